// File: rtl/fetch_unit.sv
// LC-3b instruction fetch stage: owns the PC, reads memory, hands (word, pc) to decode.
// Define FETCH_PREFETCH_EN to replace the single holding register with a 2-entry prefetch FIFO.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] mem_address,
  output logic        mem_read,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [15:0] ir_word,
  output logic [15:0] ir_pc,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [15:0] redir_pc_d;

  assign redir_pc_d  = {redirect_pc[15:1], 1'b0};
  assign mem_address = pc_q;
  assign mem_read    = (state_q == FETCH) || (state_q == DRAIN);

`ifdef FETCH_PREFETCH_EN
  logic [1:0][15:0] fw_q, fp_q;
  logic             rd_q, wr_q;
  logic [1:0]       cnt_q;
  logic             push_d, pop_d;

  assign ir_valid = (cnt_q != 2'd0);
  assign ir_word  = fw_q[rd_q];
  assign ir_pc    = fp_q[rd_q];
  assign pop_d    = ir_valid && ir_ready && !redirect;
  assign push_d   = (state_q == FETCH) && mem_resp && !redirect;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      fw_q    <= '0;
      fp_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      // A redirect empties the FIFO on the same edge; a redirected decode handshake does not count.
      if (redirect) begin
        rd_q  <= 1'b0;
        wr_q  <= 1'b0;
        cnt_q <= 2'd0;
      end else begin
        if (push_d) begin
          fw_q[wr_q] <= mem_rdata;
          fp_q[wr_q] <= pc_q;
          wr_q       <= ~wr_q;
        end
        if (pop_d) rd_q <= ~rd_q;
        cnt_q <= cnt_q + {1'b0, push_d} - {1'b0, pop_d};
      end
      case (state_q)
        IDLE: state_q <= FETCH;
        FETCH: begin
          if (redirect) begin
            pc_q    <= redir_pc_d;
            state_q <= mem_resp ? FETCH : DRAIN;
          end else if (mem_resp) begin
            pc_q <= pc_q + 16'd2;
            if (cnt_q == 2'd1 && !pop_d) state_q <= HOLD;
          end
        end
        DRAIN: begin
          if (redirect) pc_q <= redir_pc_d;
          if (mem_resp) state_q <= FETCH;
        end
        HOLD: begin
          if (redirect) begin
            pc_q    <= redir_pc_d;
            state_q <= FETCH;
          end else if (pop_d) begin
            state_q <= FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  logic [15:0] word_q, ipc_q;

  assign ir_valid = (state_q == HOLD);
  assign ir_word  = word_q;
  assign ir_pc    = ipc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      word_q  <= 16'h0000;
      ipc_q   <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: state_q <= FETCH;
        FETCH: begin
          // Data returning together with a redirect is stale; reissue at the new PC next cycle.
          if (redirect) begin
            pc_q    <= redir_pc_d;
            state_q <= mem_resp ? FETCH : DRAIN;
          end else if (mem_resp) begin
            word_q  <= mem_rdata;
            ipc_q   <= pc_q;
            pc_q    <= pc_q + 16'd2;
            state_q <= HOLD;
          end
        end
        DRAIN: begin
          // Memory cannot abort, so wait out the stale read; later redirects overwrite the PC.
          if (redirect) pc_q <= redir_pc_d;
          if (mem_resp) state_q <= FETCH;
        end
        HOLD: begin
          if (redirect) begin
            pc_q    <= redir_pc_d;
            state_q <= FETCH;
          end else if (ir_ready) begin
            state_q <= FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory responds one cycle after a request is raised.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_address;
  logic        mem_read;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir_word;
  logic [15:0] ir_pc;
  logic        redirect;
  logic [15:0] redirect_pc;

  int ncmp = 0;
  int nerr = 0;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_address(mem_address), .mem_read(mem_read),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ir_word(ir_word), .ir_pc(ir_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Inputs change #1 after an edge and are sampled at the next; outputs are observed at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_resp = 1'b0; mem_rdata = 16'h0; ir_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 16'h0;
    tick(); tick();
    ncmp++; if (mem_read !== 1'b0) begin nerr++; $display("FAIL reset_mem_read got %h want 0", mem_read); end
    ncmp++; if (mem_address !== 16'h0000) begin nerr++; $display("FAIL reset_mem_address got %h want 0000", mem_address); end
    ncmp++; if (ir_valid !== 1'b0) begin nerr++; $display("FAIL reset_ir_valid got %h want 0", ir_valid); end
    ncmp++; if (ir_word !== 16'h0000) begin nerr++; $display("FAIL reset_ir_word got %h want 0000", ir_word); end
    ncmp++; if (ir_pc !== 16'h0000) begin nerr++; $display("FAIL reset_ir_pc got %h want 0000", ir_pc); end
  endtask

  task automatic test_fetch();
    rst_n = 1'b1; ir_ready = 1'b1;
    tick();  // IDLE -> FETCH
    ncmp++; if (mem_read !== 1'b1 || mem_address !== 16'h0000) begin nerr++; $display("FAIL fetch0_req got rd=%h a=%h want rd=1 a=0000", mem_read, mem_address); end
    tick();
    mem_resp = 1'b1; mem_rdata = 16'h1234;
    tick();
    mem_resp = 1'b0;
    ncmp++; if (ir_valid !== 1'b1 || ir_word !== 16'h1234 || ir_pc !== 16'h0000) begin nerr++; $display("FAIL fetch0_ir got v=%h w=%h pc=%h want v=1 w=1234 pc=0000", ir_valid, ir_word, ir_pc); end
    ncmp++; if (mem_read !== 1'b0) begin nerr++; $display("FAIL fetch0_hold_rd got %h want 0", mem_read); end
    tick();  // handshake completes
    ncmp++; if (ir_valid !== 1'b0 || mem_read !== 1'b1 || mem_address !== 16'h0002) begin nerr++; $display("FAIL fetch1_req got v=%h rd=%h a=%h want v=0 rd=1 a=0002", ir_valid, mem_read, mem_address); end
    tick();
    mem_resp = 1'b1; mem_rdata = 16'h5678;
    tick();
    mem_resp = 1'b0; ir_ready = 1'b0;
    ncmp++; if (ir_valid !== 1'b1 || ir_word !== 16'h5678 || ir_pc !== 16'h0002) begin nerr++; $display("FAIL fetch1_ir got v=%h w=%h pc=%h want v=1 w=5678 pc=0002", ir_valid, ir_word, ir_pc); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      tick();
      ncmp++; if (ir_valid !== 1'b1 || ir_word !== 16'h5678 || ir_pc !== 16'h0002 || mem_read !== 1'b0) begin nerr++; $display("FAIL stall_%0d got v=%h w=%h pc=%h rd=%h want v=1 w=5678 pc=0002 rd=0", i, ir_valid, ir_word, ir_pc, mem_read); end
    end
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    ncmp++; if (ir_valid !== 1'b0 || mem_read !== 1'b1 || mem_address !== 16'h0004) begin nerr++; $display("FAIL stall_release got v=%h rd=%h a=%h want v=0 rd=1 a=0004", ir_valid, mem_read, mem_address); end
  endtask

  task automatic test_redirect_drain();
    redirect = 1'b1; redirect_pc = 16'h3001;
    tick();
    redirect = 1'b0;
    ncmp++; if (mem_read !== 1'b1 || mem_address !== 16'h3000 || ir_valid !== 1'b0) begin nerr++; $display("FAIL drain_enter got rd=%h a=%h v=%h want rd=1 a=3000 v=0", mem_read, mem_address, ir_valid); end
    tick(); tick();
    mem_resp = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_resp = 1'b0;
    ncmp++; if (ir_valid !== 1'b0 || mem_read !== 1'b1 || mem_address !== 16'h3000) begin nerr++; $display("FAIL drain_exit got v=%h rd=%h a=%h want v=0 rd=1 a=3000", ir_valid, mem_read, mem_address); end
    tick();
    mem_resp = 1'b1; mem_rdata = 16'h1111; ir_ready = 1'b1;
    tick();
    mem_resp = 1'b0;
    ncmp++; if (ir_valid !== 1'b1 || ir_word !== 16'h1111 || ir_pc !== 16'h3000) begin nerr++; $display("FAIL drain_next_ir got v=%h w=%h pc=%h want v=1 w=1111 pc=3000", ir_valid, ir_word, ir_pc); end
    tick();
    ir_ready = 1'b0;
    ncmp++; if (mem_address !== 16'h3002 || mem_read !== 1'b1) begin nerr++; $display("FAIL drain_next_req got a=%h rd=%h want a=3002 rd=1", mem_address, mem_read); end
  endtask

  task automatic test_redirect_same_cycle();
    tick();
    mem_resp = 1'b1; mem_rdata = 16'hBEEF; redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    mem_resp = 1'b0; redirect = 1'b0;
    ncmp++; if (ir_valid !== 1'b0 || mem_read !== 1'b1 || mem_address !== 16'hFFFE) begin nerr++; $display("FAIL same_cycle got v=%h rd=%h a=%h want v=0 rd=1 a=FFFE", ir_valid, mem_read, mem_address); end
  endtask

  task automatic test_wrap();
    tick();
    mem_resp = 1'b1; mem_rdata = 16'h0F25;
    tick();
    mem_resp = 1'b0;
    ncmp++; if (ir_valid !== 1'b1 || ir_word !== 16'h0F25 || ir_pc !== 16'hFFFE) begin nerr++; $display("FAIL wrap_ir got v=%h w=%h pc=%h want v=1 w=0F25 pc=FFFE", ir_valid, ir_word, ir_pc); end
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    ncmp++; if (mem_address !== 16'h0000 || mem_read !== 1'b1) begin nerr++; $display("FAIL wrap_req got a=%h rd=%h want a=0000 rd=1", mem_address, mem_read); end
  endtask

  task automatic test_hold_redirect();
    tick();
    mem_resp = 1'b1; mem_rdata = 16'h2222;
    tick();
    mem_resp = 1'b0;
    // Decode says ready in the same cycle as the redirect; the transfer is squashed.
    ir_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0200;
    tick();
    ir_ready = 1'b0; redirect = 1'b0;
    ncmp++; if (ir_valid !== 1'b0 || mem_read !== 1'b1 || mem_address !== 16'h0200) begin nerr++; $display("FAIL hold_redirect got v=%h rd=%h a=%h want v=0 rd=1 a=0200", ir_valid, mem_read, mem_address); end
  endtask

  task automatic test_reset_mid();
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick();  // now in DRAIN
    redirect = 1'b0; rst_n = 1'b0;
    tick();
    ncmp++; if (mem_read !== 1'b0 || mem_address !== 16'h0000 || ir_valid !== 1'b0 || ir_word !== 16'h0000 || ir_pc !== 16'h0000) begin nerr++; $display("FAIL reset_mid got rd=%h a=%h v=%h w=%h pc=%h want all zero", mem_read, mem_address, ir_valid, ir_word, ir_pc); end
    rst_n = 1'b1; mem_resp = 1'b1; mem_rdata = 16'hDEAD;  // late response lands in IDLE
    tick();
    mem_resp = 1'b0;
    ncmp++; if (ir_valid !== 1'b0 || mem_read !== 1'b1 || mem_address !== 16'h0000) begin nerr++; $display("FAIL reset_restart got v=%h rd=%h a=%h want v=0 rd=1 a=0000", ir_valid, mem_read, mem_address); end
    tick();
    mem_resp = 1'b1; mem_rdata = 16'h1234;
    tick();
    mem_resp = 1'b0;
    ncmp++; if (ir_valid !== 1'b1 || ir_word !== 16'h1234 || ir_pc !== 16'h0000) begin nerr++; $display("FAIL reset_refetch got v=%h w=%h pc=%h want v=1 w=1234 pc=0000", ir_valid, ir_word, ir_pc); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_drain();
    test_redirect_same_cycle();
    test_wrap();
    test_hold_redirect();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1);
  end
endmodule
